// File: rtl/gate_selftest_pkg.sv
// Shared definitions for the two-input gate self-test: FSM states, gate bit
// positions within the gates vector, and the golden truth table.
package gate_selftest_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int AND_B   = 7;
    localparam int OR_B    = 6;
    localparam int NOT_A_B = 5;
    localparam int NOT_B_B = 4;
    localparam int NAND_B  = 3;
    localparam int NOR_B   = 2;
    localparam int XOR_B   = 1;
    localparam int XNOR_B  = 0;

    // Indexed by {a,b}.
    localparam logic [7:0] GOLDEN [4] = '{8'h3D, 8'h6A, 8'h5A, 8'hC1};

endpackage

// File: rtl/gate_selftest_seq_golden_ref.sv
// Expected gate output vector for a given pair of gate inputs.
module gate_golden_ref
    import gate_selftest_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [7:0] exp_o
);

    assign exp_o = GOLDEN[{a_i, b_i}];

endmodule

// File: rtl/gate_selftest_seq.sv
// Sequential self-test: steps a/b through all four combinations, samples the
// gate outputs after a settle window and accumulates a pass/fail verdict.
module gate_selftest_seq
    import gate_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] gates_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic [1:0] idx_d;
    logic [7:0] golden;
    logic       mismatch;

    gate_golden_ref u_golden (
        .a_i   (idx_q[1]),
        .b_i   (idx_q[0]),
        .exp_o (golden)
    );

    assign idx_d    = idx_q + 2'd1;
    // Case inequality so an undriven/X gate output counts as a failure.
    assign mismatch = (gates_i !== golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 4'd0;
            a_o          <= 1'b0;
            b_o          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            pass         <= 1'b0;
            err_count    <= 3'd0;
            fail_mask    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx_q        <= 2'd0;
                        a_o          <= 1'b0;
                        b_o          <= 1'b0;
                        cnt_q        <= 4'd0;
                        err_count    <= 3'd0;
                        fail_mask    <= 4'd0;
                        result_valid <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_mask[idx_q] <= 1'b1;
                        if (err_count != 3'd4) begin
                            err_count <= err_count + 3'd1;
                        end
                    end
                    if (idx_q == 2'd3) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_d;
                        a_o     <= idx_d[1];
                        b_o     <= idx_d[0];
                        cnt_q   <= 4'd0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    // err_count already includes the final SAMPLE's result.
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                    pass         <= (err_count == 3'd0);
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Directed and randomized bench for gate_selftest_seq: emulates the gates block
// with injectable faults and predicts the verdict from the fault pattern.
`timescale 1ns/1ps
module tb_gate_selftest_seq;
    import gate_selftest_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] gates0, gates1;
    logic       a0, b0, busy0, done0, rv0, pass0;
    logic       a1, b1, busy1, done1, rv1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] mask0, mask1;
    logic [7:0] corrupt [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] glitch0 = 8'h00, glitch1 = 8'h00;
    logic       sel = 1'b0;
    logic       ra = 1'b0, rb = 1'b0;
    logic [7:0] rexp;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Behavioural gates block: ideal logic functions of a/b.
    function automatic logic [7:0] ideal(input logic a, input logic b);
        logic [7:0] v;
        v          = 8'h00;
        v[AND_B]   = a & b;
        v[OR_B]    = a | b;
        v[NOT_A_B] = ~a;
        v[NOT_B_B] = ~b;
        v[NAND_B]  = ~(a & b);
        v[NOR_B]   = ~(a | b);
        v[XOR_B]   = a ^ b;
        v[XNOR_B]  = ~(a ^ b);
        return v;
    endfunction

    assign gates0 = ideal(a0, b0) ^ corrupt[{a0, b0}] ^ glitch0;
    assign gates1 = ideal(a1, b1) ^ corrupt[{a1, b1}] ^ glitch1;

    gate_selftest_seq u_dut (
        .clk(clk), .rst(rst), .start(start0), .gates_i(gates0),
        .a_o(a0), .b_o(b0), .busy(busy0), .done(done0),
        .result_valid(rv0), .pass(pass0), .err_count(err0), .fail_mask(mask0)
    );

    gate_selftest_seq #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gates_i(gates1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1),
        .result_valid(rv1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
    );

    gate_golden_ref u_gr (.a_i(ra), .b_i(rb), .exp_o(rexp));

    logic       a_s, b_s, busy_s, done_s, rv_s, pass_s;
    logic [2:0] err_s;
    logic [3:0] mask_s;
    assign a_s    = sel ? a1 : a0;
    assign b_s    = sel ? b1 : b0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign rv_s   = sel ? rv1 : rv0;
    assign pass_s = sel ? pass1 : pass0;
    assign err_s  = sel ? err1 : err0;
    assign mask_s = sel ? mask1 : mask0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic set_glitch(input logic [7:0] v);
        if (sel) glitch1 = v; else glitch0 = v;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ab"}, {30'd0, a_s, b_s}, 32'd0);
        chk({tag, "_busy"}, busy_s, 1'b0);
        chk({tag, "_done"}, done_s, 1'b0);
        chk({tag, "_rv"}, rv_s, 1'b0);
        chk({tag, "_pass"}, pass_s, 1'b0);
        chk({tag, "_err"}, err_s, 3'd0);
        chk({tag, "_mask"}, mask_s, 4'd0);
    endtask

    // One test run on the selected instance. k counts clock edges after the
    // edge that accepted start; checks happen on the falling edge after edge k.
    task automatic run(input int s, input int repulse_at, input bit chain,
                       input bit skip_start, input bit glitch_en);
        int         lat;
        int         ecnt;
        bit         seen;
        logic [3:0] emask;
        lat   = 4 * (s + 1) + 1;
        ecnt  = 0;
        emask = 4'd0;
        seen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (corrupt[c] != 8'h00) begin
                emask[c] = 1'b1;
                ecnt++;
            end
        end
        if (!skip_start) begin
            @(negedge clk);
            set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
        end
        for (int k = 0; k <= lat + 10; k++) begin
            if (k < 4 * (s + 1)) begin
                chk("ab_step", {30'd0, a_s, b_s}, k / (s + 1));
                chk("busy_run", busy_s, 1'b1);
            end
            set_glitch((glitch_en && k < 4 * (s + 1) && (k % (s + 1)) != s)
                       ? 8'($urandom) : 8'h00);
            if (done_s) begin
                seen = 1'b1;
                chk("done_at", k, lat);
                chk("busy_end", busy_s, 1'b0);
                chk("rv_set", rv_s, 1'b1);
                chk("pass", pass_s, (ecnt == 0));
                chk("err_count", err_s, ecnt);
                chk("fail_mask", mask_s, emask);
                if (!chain) begin
                    @(negedge clk);
                    chk("done_drop", done_s, 1'b0);
                    chk("rv_hold", rv_s, 1'b1);
                    break;
                end
            end
            if (chain && k == lat + 1) begin
                chk("rerun_busy", busy_s, 1'b1);
                chk("rerun_rv", rv_s, 1'b0);
                chk("rerun_ab", {30'd0, a_s, b_s}, 32'd0);
                set_start(1'b0);
                break;
            end
            set_start((k == repulse_at) || (chain && (k == lat - 1 || k == lat)));
            @(negedge clk);
        end
        set_glitch(8'h00);
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic randomize_faults();
        for (int c = 0; c < 4; c++) begin
            corrupt[c] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        for (int c = 0; c < 4; c++) begin
            ra = c[1];
            rb = c[0];
            #1;
            chk("golden_ref", rexp, ideal(ra, rb));
        end

        run(2, -1, 0, 0, 0);

        for (int c = 0; c < 4; c++) corrupt[c] = ideal(c[1], c[0]) & (8'h01 << XOR_B);
        run(2, -1, 0, 0, 0);

        for (int c = 0; c < 4; c++) corrupt[c] = ideal(c[1], c[0]);
        run(2, -1, 0, 0, 0);

        for (int c = 0; c < 4; c++) corrupt[c] = 8'h00;
        run(2, 5, 0, 0, 0);

        // Reset during the second settle window, then a clean rerun.
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_ab", {30'd0, a_s, b_s}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("mid_reset");
        run(2, -1, 0, 0, 0);

        // start coincident with reset is dropped.
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        rst    = 1'b0;
        check_idle_zero("start_rst");
        @(negedge clk);
        chk("start_rst_busy", busy_s, 1'b0);

        // start held across DONE: ignored there, accepted in the next IDLE.
        run(2, -1, 1, 0, 0);
        randomize_faults();
        run(2, -1, 0, 1, 0);

        for (int i = 0; i < 6; i++) begin
            randomize_faults();
            run(2, -1, 0, 0, 1);
        end

        sel = 1'b1;
        for (int c = 0; c < 4; c++) corrupt[c] = 8'h00;
        run(1, -1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            randomize_faults();
            run(1, -1, 0, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
